pe_array_seq: RTL and testbench

PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

---
 rtl/pe_ctrl_pkg.sv | 23 ++
 rtl/pe_array_seq_skew_line.sv | 44 ++++
 rtl/pe_array_seq.sv | 202 ++++++++++++++++++++
 tb/tb_pe_array_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// ============================================================================
//  pe_ctrl_pkg : shared constants and controller state type for pe_array_seq
//  Rev 1.0
// ============================================================================
`default_nettype none

package pe_ctrl_pkg;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAT = 2 * N;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pe_array_seq_skew_line.sv
// ============================================================================
//  skew_line : resettable DEPTH-stage delay line, DEPTH=0 is a plain wire
//  Rev 1.0
// ============================================================================
`default_nettype none

module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk | rst;
      assign o_q = i_d;
    end else begin : g_reg
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_stage[k] <= '0;
          end
        end else begin
          r_stage[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_array_seq.sv
// ============================================================================
//  pe_array_seq : controller for an N x N weight-stationary PE array
//  (weight load, skewed activation feed, deskewed result collection)
//  Rev 1.0
// ============================================================================
`default_nettype none

module pe_array_seq #(
  parameter int N  = pe_ctrl_pkg::N,
  parameter int DW = pe_ctrl_pkg::DW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic                                i_cfg_reuse_w,
  input  logic [7:0]                          i_cfg_num_vec,
  output logic                                o_busy,
  output logic                                o_done,
  input  logic                                i_w_valid,
  output logic                                o_w_ready,
  input  logic [DW-1:0]                       i_w_data,
  input  logic                                i_a_valid,
  output logic                                o_a_ready,
  input  logic [N*DW-1:0]                     i_a_data,
  output logic                                o_init_wr_en,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_init_wr_row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_init_wr_col,
  output logic [DW-1:0]                       o_init_wr_data,
  output logic [N*DW-1:0]                     o_arr_a,
  input  logic [N*DW-1:0]                     i_arr_down,
  output logic                                o_res_valid,
  output logic [N*DW-1:0]                     o_res_data
);

  import pe_ctrl_pkg::*;

  localparam int c_RW  = (N > 1) ? $clog2(N) : 1;
  localparam int c_LAT = 2 * N;
  localparam int c_DCW = $clog2(c_LAT);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_w_ready;
  logic              r_a_ready;
  logic [c_RW-1:0]   r_wr_row;
  logic [c_RW-1:0]   r_wr_col;
  logic [7:0]        r_num_vec;
  logic [7:0]        r_a_cnt;
  logic [c_DCW-1:0]  r_drain_cnt;

  logic              w_w_hs;
  logic              w_a_hs;
  logic              w_col_last;
  logic              w_row_last;
  logic [N*DW-1:0]   w_skew_in;
  logic [N*DW-1:0]   w_deskew_out;
  logic              w_tag_out;

  assign w_w_hs     = i_w_valid & r_w_ready;
  assign w_a_hs     = i_a_valid & r_a_ready;
  assign w_col_last = (r_wr_col == c_RW'(N - 1));
  assign w_row_last = (r_wr_row == c_RW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_ready   <= 1'b0;
      r_a_ready   <= 1'b0;
      r_wr_row    <= '0;
      r_wr_col    <= '0;
      r_num_vec   <= '0;
      r_a_cnt     <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_vec <= i_cfg_num_vec;
            r_busy    <= 1'b1;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_a_cnt   <= '0;
            if (i_cfg_reuse_w) begin
              r_state   <= S_STREAM;
              r_a_ready <= (i_cfg_num_vec != 8'd0);
            end else begin
              r_state   <= S_LOAD_W;
              r_w_ready <= 1'b1;
            end
          end
        end

        // Column index runs fastest so the row-major weight stream maps 1:1.
        S_LOAD_W: begin
          if (w_w_hs) begin
            if (w_col_last) begin
              r_wr_col <= '0;
              r_wr_row <= r_wr_row + 1'b1;
            end else begin
              r_wr_col <= r_wr_col + 1'b1;
            end
            if (w_col_last && w_row_last) begin
              r_w_ready <= 1'b0;
              r_wr_row  <= '0;
              if (r_num_vec == 8'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_STREAM;
                r_a_ready <= 1'b1;
              end
            end
          end
        end

        S_STREAM: begin
          if (r_num_vec == 8'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_a_hs) begin
            r_a_cnt <= r_a_cnt + 8'd1;
            if (r_a_cnt == r_num_vec - 8'd1) begin
              r_a_ready   <= 1'b0;
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end
        end

        // Long enough for the last accepted vector to reach o_res_data.
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (r_drain_cnt == c_DCW'(c_LAT - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_w_ready <= 1'b0;
          r_a_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_w_ready      = r_w_ready;
  assign o_a_ready      = r_a_ready;
  assign o_init_wr_en   = w_w_hs;
  assign o_init_wr_row  = r_wr_row;
  assign o_init_wr_col  = r_wr_col;
  assign o_init_wr_data = w_w_hs ? i_w_data : '0;

  generate
    for (genvar r = 0; r < N; r++) begin : g_skew
      assign w_skew_in[r*DW +: DW] = w_a_hs ? i_a_data[r*DW +: DW] : '0;

      skew_line #(.DEPTH(r + 1), .WIDTH(DW)) u_skew (
        .clk (clk),
        .rst (rst),
        .i_d (w_skew_in[r*DW +: DW]),
        .o_q (o_arr_a[r*DW +: DW])
      );
    end

    // Column c leaves the array c cycles after column 0; pad the early ones.
    for (genvar c = 0; c < N; c++) begin : g_deskew
      skew_line #(.DEPTH(N - 1 - c), .WIDTH(DW)) u_deskew (
        .clk (clk),
        .rst (rst),
        .i_d (i_arr_down[c*DW +: DW]),
        .o_q (w_deskew_out[c*DW +: DW])
      );
    end
  endgenerate

  skew_line #(.DEPTH(c_LAT), .WIDTH(1)) u_tag (
    .clk (clk),
    .rst (rst),
    .i_d (w_a_hs),
    .o_q (w_tag_out)
  );

  assign o_res_valid = w_tag_out;
  assign o_res_data  = w_tag_out ? w_deskew_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_pe_array_seq.sv
// ============================================================================
//  tb_pe_array_seq : randomized bench for pe_array_seq with a systolic array
//  model and a matrix-vector reference
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pe_array_seq;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAT = 2 * N;
  localparam int VW  = N * DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start, i_cfg_reuse_w;
  logic [7:0]     i_cfg_num_vec;
  logic           o_busy, o_done;
  logic           i_w_valid, o_w_ready;
  logic [DW-1:0]  i_w_data;
  logic           i_a_valid, o_a_ready;
  logic [VW-1:0]  i_a_data;
  logic           o_init_wr_en;
  logic [1:0]     o_init_wr_row, o_init_wr_col;
  logic [DW-1:0]  o_init_wr_data;
  logic [VW-1:0]  o_arr_a, i_arr_down;
  logic           o_res_valid;
  logic [VW-1:0]  o_res_data;

  always #5 clk = ~clk;

  pe_array_seq #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_cfg_reuse_w(i_cfg_reuse_w), .i_cfg_num_vec(i_cfg_num_vec),
    .o_busy(o_busy), .o_done(o_done),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_data(i_a_data),
    .o_init_wr_en(o_init_wr_en), .o_init_wr_row(o_init_wr_row),
    .o_init_wr_col(o_init_wr_col), .o_init_wr_data(o_init_wr_data),
    .o_arr_a(o_arr_a), .i_arr_down(i_arr_down),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data)
  );

  // Weight-stationary array: activations move right, partial sums move down.
  logic [DW-1:0] pw    [N][N];
  logic [DW-1:0] a_reg [N][N];
  logic [DW-1:0] p_reg [N][N];
  logic [DW-1:0] m_ain, m_pin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_reg[r][c] <= '0;
          p_reg[r][c] <= '0;
        end
    end else begin
      if (o_init_wr_en) pw[o_init_wr_row][o_init_wr_col] <= o_init_wr_data;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (c == 0) m_ain = o_arr_a[r*DW +: DW];
          else        m_ain = a_reg[r][c-1];
          if (r == 0) m_pin = '0;
          else        m_pin = p_reg[r-1][c];
          a_reg[r][c] <= m_ain;
          p_reg[r][c] <= m_pin + m_ain * pw[r][c];
        end
    end
  end

  always_comb begin
    i_arr_down = '0;
    for (int c = 0; c < N; c++) i_arr_down[c*DW +: DW] = p_reg[N-1][c];
  end

  // Monitor: samples on the falling edge, between active edges.
  int            cyc = 0;
  logic [VW-1:0] res_q[$];
  int            res_cyc_q[$];
  int            hs_cyc_q[$];
  int            done_cnt, done_cyc, wr_en_cnt, wrdy_cnt, ardy_cnt, both_cnt;
  logic [VW-1:0] arr_log [4096];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    arr_log[cyc % 4096] = o_arr_a;
    if (o_res_valid) begin res_q.push_back(o_res_data); res_cyc_q.push_back(cyc); end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_init_wr_en) wr_en_cnt++;
    if (o_w_ready) wrdy_cnt++;
    if (o_a_ready) ardy_cnt++;
    if (o_w_ready && o_a_ready) both_cnt++;
    if (i_a_valid && o_a_ready) hs_cyc_q.push_back(cyc);
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ld_w  [N*N];
  logic [DW-1:0] res_w [N*N];
  logic [VW-1:0] vecs[$];

  // Reference: y[c] = sum_r x[r] * W[r][c], modulo 2^DW.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
    logic [VW-1:0] o;
    int s;
    o = '0;
    for (int c = 0; c < N; c++) begin
      s = 0;
      for (int r = 0; r < N; r++) s += int'(v[r*DW +: DW]) * int'(res_w[r*N + c]);
      o[c*DW +: DW] = s[DW-1:0];
    end
    return o;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'($urandom_range(1, 255));
    return v;
  endfunction

  task automatic clear_mon();
    res_q.delete(); res_cyc_q.delete(); hs_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; wr_en_cnt = 0; wrdy_cnt = 0; ardy_cnt = 0; both_cnt = 0;
  endtask

  // vmode: 0 = always valid, 1 = random valid, 2 = valid on alternate cycles
  task automatic run_job(input bit reuse, input int nv, input int vmode);
    int idx, guard, step;
    bit hs;
    @(posedge clk); #1;
    i_start = 1'b1; i_cfg_reuse_w = reuse; i_cfg_num_vec = nv[7:0];
    @(posedge clk); #1;
    i_start = 1'b0;
    if (!reuse) begin
      idx = 0; guard = 0;
      while (idx < N*N && guard < 500) begin
        i_w_valid = ($urandom_range(0, 3) != 0);
        i_w_data  = ld_w[idx];
        @(negedge clk); hs = i_w_valid && o_w_ready;
        @(posedge clk); #1;
        if (hs) idx++;
        guard++;
      end
      i_w_valid = 1'b0;
      for (int k = 0; k < N*N; k++) res_w[k] = ld_w[k];
    end
    idx = 0; guard = 0; step = 0;
    while (idx < nv && guard < 500) begin
      case (vmode)
        0:       i_a_valid = 1'b1;
        1:       i_a_valid = ($urandom_range(0, 2) != 0);
        default: i_a_valid = (step % 2 == 0);
      endcase
      i_a_data = vecs[idx];
      @(negedge clk); hs = i_a_valid && o_a_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++; step++;
    end
    i_a_valid = 1'b0; i_a_data = '0;
    guard = 0;
    @(negedge clk);
    while (o_busy && guard < 200) begin @(negedge clk); guard++; end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL job_timeout: busy=%b required 0 (nv=%0d)", o_busy, nv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_busy, o_done, o_w_ready, o_a_ready, o_init_wr_en, o_res_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000",
        {o_busy, o_done, o_w_ready, o_a_ready, o_init_wr_en, o_res_valid});
    end
    n_tests++;
    if (o_arr_a !== '0) begin n_fail++; $display("FAIL reset_arr_a: got %h required 0", o_arr_a); end
    n_tests++;
    if (o_res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %h required 0", o_res_data); end
    n_tests++;
    if ({o_init_wr_row, o_init_wr_col, o_init_wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_init_wr: got %h required 0", {o_init_wr_row, o_init_wr_col, o_init_wr_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int h;
    clear_mon();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) ld_w[r*N + c] = (r == c) ? 8'd1 : 8'd0;
    vecs.delete();
    vecs.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    vecs.push_back({8'd8, 8'd7, 8'd6, 8'd5});
    vecs.push_back({8'd12, 8'd11, 8'd10, 8'd9});
    run_job(1'b0, 3, 0);
    n_tests++;
    if (res_q.size() !== 3) begin n_fail++; $display("FAIL ident_count: got %0d required 3", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < 3 && i < hs_cyc_q.size(); i++) begin
      n_tests++;
      if (res_q[i] !== vecs[i]) begin n_fail++; $display("FAIL ident_data[%0d]: got %h required %h", i, res_q[i], vecs[i]); end
      n_tests++;
      if (res_cyc_q[i] !== hs_cyc_q[i] + LAT) begin
        n_fail++; $display("FAIL ident_latency[%0d]: got %0d required %0d", i, res_cyc_q[i] - hs_cyc_q[i], LAT);
      end
    end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL ident_done_count: got %0d required 1", done_cnt); end
    h = (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : 0;
    n_tests++;
    if (done_cyc !== h + LAT + 1) begin n_fail++; $display("FAIL ident_done_time: got %0d required %0d", done_cyc, h + LAT + 1); end
    n_tests++;
    if (wr_en_cnt !== N*N) begin n_fail++; $display("FAIL ident_weight_writes: got %0d required %0d", wr_en_cnt, N*N); end
    n_tests++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL ident_ready_overlap: got %0d required 0", both_cnt); end
  endtask

  task automatic test_mod_wrap();
    clear_mon();
    for (int k = 0; k < N*N; k++) ld_w[k] = 8'd2;
    vecs.delete();
    vecs.push_back({4{8'd100}});
    run_job(1'b0, 1, 0);
    n_tests++;
    if (res_q.size() !== 1) begin n_fail++; $display("FAIL wrap_count: got %0d required 1", res_q.size()); end
    else begin
      n_tests++;
      if (res_q[0] !== {4{8'd32}}) begin n_fail++; $display("FAIL wrap_data: got %h required %h", res_q[0], {4{8'd32}}); end
    end
  endtask

  task automatic test_random();
    int nv;
    for (int it = 0; it < 3; it++) begin
      clear_mon();
      for (int k = 0; k < N*N; k++) ld_w[k] = DW'($urandom);
      nv = $urandom_range(1, 5);
      vecs.delete();
      for (int i = 0; i < nv; i++) vecs.push_back(rand_vec());
      run_job(1'b0, nv, $urandom_range(0, 1));
      n_tests++;
      if (res_q.size() !== nv) begin n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", it, res_q.size(), nv); end
      for (int i = 0; i < res_q.size() && i < nv && i < hs_cyc_q.size(); i++) begin
        n_tests++;
        if (res_q[i] !== model(vecs[i])) begin
          n_fail++; $display("FAIL rand%0d_data[%0d]: got %h required %h", it, i, res_q[i], model(vecs[i]));
        end
        n_tests++;
        if (res_cyc_q[i] !== hs_cyc_q[i] + LAT) begin
          n_fail++; $display("FAIL rand%0d_latency[%0d]: got %0d required %0d", it, i, res_cyc_q[i] - hs_cyc_q[i], LAT);
        end
      end
      n_tests++;
      if (done_cnt !== 1 || both_cnt !== 0) begin
        n_fail++; $display("FAIL rand%0d_done_overlap: done=%0d overlap=%0d required 1,0", it, done_cnt, both_cnt);
      end
    end
  endtask

  task automatic test_reuse();
    clear_mon();
    vecs.delete();
    vecs.push_back(rand_vec());
    vecs.push_back(rand_vec());
    run_job(1'b1, 2, 0);
    n_tests++;
    if (wrdy_cnt !== 0 || wr_en_cnt !== 0) begin
      n_fail++; $display("FAIL reuse_no_load: w_ready cycles=%0d writes=%0d required 0,0", wrdy_cnt, wr_en_cnt);
    end
    n_tests++;
    if (res_q.size() !== 2) begin n_fail++; $display("FAIL reuse_count: got %0d required 2", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < 2; i++) begin
      n_tests++;
      if (res_q[i] !== model(vecs[i])) begin
        n_fail++; $display("FAIL reuse_data[%0d]: got %h required %h", i, res_q[i], model(vecs[i]));
      end
    end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL reuse_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_bubble();
    int h0, h1;
    logic [VW-1:0] t;
    clear_mon();
    vecs.delete();
    vecs.push_back(rand_vec());
    vecs.push_back(rand_vec());
    run_job(1'b1, 2, 2);
    n_tests++;
    if (hs_cyc_q.size() !== 2 || res_q.size() !== 2) begin
      n_fail++; $display("FAIL bubble_count: hs=%0d res=%0d required 2,2", hs_cyc_q.size(), res_q.size());
    end else begin
      h0 = hs_cyc_q[0]; h1 = hs_cyc_q[1];
      n_tests++;
      if (h1 - h0 !== 2) begin n_fail++; $display("FAIL bubble_hs_gap: got %0d required 2", h1 - h0); end
      n_tests++;
      if (res_cyc_q[1] - res_cyc_q[0] !== 2) begin
        n_fail++; $display("FAIL bubble_res_gap: got %0d required 2", res_cyc_q[1] - res_cyc_q[0]);
      end
      t = arr_log[(h0 + 1) % 4096];
      n_tests++;
      if (t[DW-1:0] !== vecs[0][DW-1:0]) begin n_fail++; $display("FAIL bubble_row0_v0: got %h required %h", t[DW-1:0], vecs[0][DW-1:0]); end
      t = arr_log[(h0 + 2) % 4096];
      n_tests++;
      if (t[DW-1:0] !== '0) begin n_fail++; $display("FAIL bubble_row0_zero: got %h required 00", t[DW-1:0]); end
      t = arr_log[(h0 + 3) % 4096];
      n_tests++;
      if (t[DW-1:0] !== vecs[1][DW-1:0]) begin n_fail++; $display("FAIL bubble_row0_v1: got %h required %h", t[DW-1:0], vecs[1][DW-1:0]); end
      t = arr_log[(h0 + N) % 4096];
      n_tests++;
      if (t[VW-1 -: DW] !== vecs[0][VW-1 -: DW]) begin
        n_fail++; $display("FAIL bubble_skew_last_row: got %h required %h", t[VW-1 -: DW], vecs[0][VW-1 -: DW]);
      end
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (res_q[i] !== model(vecs[i])) begin
          n_fail++; $display("FAIL bubble_data[%0d]: got %h required %h", i, res_q[i], model(vecs[i]));
        end
      end
    end
  endtask

  task automatic test_nv0();
    clear_mon();
    for (int k = 0; k < N*N; k++) ld_w[k] = DW'($urandom);
    vecs.delete();
    run_job(1'b0, 0, 0);
    n_tests++;
    if (wr_en_cnt !== N*N) begin n_fail++; $display("FAIL nv0_writes: got %0d required %0d", wr_en_cnt, N*N); end
    n_tests++;
    if (ardy_cnt !== 0) begin n_fail++; $display("FAIL nv0_a_ready: got %0d cycles required 0", ardy_cnt); end
    n_tests++;
    if (done_cnt !== 1 || res_q.size() !== 0) begin
      n_fail++; $display("FAIL nv0_done_res: done=%0d res=%0d required 1,0", done_cnt, res_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int idx, guard;
    bit hs;
    clear_mon();
    vecs.delete();
    for (int i = 0; i < 4; i++) vecs.push_back(rand_vec());
    @(posedge clk); #1;
    i_start = 1'b1; i_cfg_reuse_w = 1'b1; i_cfg_num_vec = 8'd4;
    @(posedge clk); #1;
    i_start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 2 && guard < 50) begin
      i_a_valid = 1'b1; i_a_data = vecs[idx];
      @(negedge clk); hs = i_a_valid && o_a_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    i_a_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({o_busy, o_done, o_w_ready, o_a_ready, o_init_wr_en, o_res_valid} !== 6'b0 || o_arr_a !== '0 || o_res_data !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: ctrl=%b arr_a=%h res=%h required all 0",
        {o_busy, o_done, o_w_ready, o_a_ready, o_init_wr_en, o_res_valid}, o_arr_a, o_res_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    n_tests++;
    if (res_q.size() !== 0 || done_cnt !== 0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abandon: res=%0d done=%0d busy=%b required 0,0,0", res_q.size(), done_cnt, o_busy);
    end
    clear_mon();
    for (int k = 0; k < N*N; k++) ld_w[k] = DW'($urandom);
    vecs.delete();
    vecs.push_back(rand_vec());
    vecs.push_back(rand_vec());
    run_job(1'b0, 2, 1);
    n_tests++;
    if (res_q.size() !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL midrst_fresh_count: res=%0d done=%0d required 2,1", res_q.size(), done_cnt);
    end
    for (int i = 0; i < res_q.size() && i < 2; i++) begin
      n_tests++;
      if (res_q[i] !== model(vecs[i])) begin
        n_fail++; $display("FAIL midrst_fresh_data[%0d]: got %h required %h", i, res_q[i], model(vecs[i]));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_cfg_reuse_w = 1'b0; i_cfg_num_vec = '0;
    i_w_valid = 1'b0; i_w_data = '0; i_a_valid = 1'b0; i_a_data = '0;
    clear_mon();
    test_reset();
    test_identity();
    test_mod_wrap();
    test_random();
    test_reuse();
    test_bubble();
    test_nv0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
